// File: rtl/idu_ctrl_queue_if.sv
// Handshake bundle between IFU, the decode queue and EXU.
// Upstream side: in_valid/in_ready with in_inst/in_pc, plus the redirect flush.
// Downstream side: out_valid/out_ready with the decoded control bundle of the head entry.
// modport master: the decode queue's view (drives in_ready and all out_* signals).
// modport slave : the surrounding pipeline's view (drives instructions, flush, out_ready).
interface idu_ctrl_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  out_extOP;
  logic        out_readMemEnable;
  logic        out_writeMemEnable;
  logic        out_rdEnable;
  logic [2:0]  out_memOP;
  logic [2:0]  out_branchOP;
  logic [3:0]  out_ALUCtrl;
  logic        out_ALUASel;
  logic [1:0]  out_ALUBSel;
  logic        out_mulEn;
  logic        out_csrEn;
  logic        out_sysTrap;
  logic        out_illegal;

  modport master (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, out_extOP,
           out_readMemEnable, out_writeMemEnable, out_rdEnable, out_memOP,
           out_branchOP, out_ALUCtrl, out_ALUASel, out_ALUBSel,
           out_mulEn, out_csrEn, out_sysTrap, out_illegal
  );

  modport slave (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, out_extOP,
           out_readMemEnable, out_writeMemEnable, out_rdEnable, out_memOP,
           out_branchOP, out_ALUCtrl, out_ALUASel, out_ALUBSel,
           out_mulEn, out_csrEn, out_sysTrap, out_illegal
  );
endinterface

// File: rtl/idu_ctrl_queue.sv
// RV32 instruction-decode control stage with a DEPTH-entry output FIFO.
// Each accepted instruction is decoded combinationally and the full control
// bundle is stored; the head entry drives the outputs (no in->out bypass).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (clears pointers, count and storage)
//   bus   - idu_ctrl_queue_if.master: in_* handshake, flush, out_* bundle
module idu_ctrl_queue #(
  parameter int DEPTH      = 2,
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_CSR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  idu_ctrl_queue_if.master  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [2:0]  ext_op;
    logic        rd_mem;
    logic        wr_mem;
    logic        rd_en;
    logic [2:0]  mem_op;
    logic [2:0]  branch_op;
    logic [3:0]  alu_ctrl;
    logic        alu_a_sel;
    logic [1:0]  alu_b_sel;
    logic        mul_en;
    logic        csr_en;
    logic        sys_trap;
    logic        illegal;
  } entry_t;

  // Full decode of one instruction word. The opcode match covers inst[1:0],
  // so compressed encodings fall into the unknown-opcode case.
  function automatic entry_t decode(input logic [31:0] inst, input logic [31:0] pc);
    entry_t     d;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       bad;
    opc      = inst[6:0];
    f3       = inst[14:12];
    f7       = inst[31:25];
    d        = '0;
    d.pc     = pc;
    d.inst   = inst;
    d.mem_op = f3;
    bad      = 1'b0;
    case (opc)
      OPC_LUI: begin
        d.ext_op   = 3'b001;
        d.rd_en    = 1'b1;
        d.alu_ctrl = 4'b1011;
      end
      OPC_AUIPC: begin
        d.ext_op    = 3'b001;
        d.rd_en     = 1'b1;
        d.alu_a_sel = 1'b1;
        d.alu_b_sel = 2'b10;
      end
      OPC_JAL: begin
        d.ext_op    = 3'b100;
        d.rd_en     = 1'b1;
        d.branch_op = 3'b001;
        d.alu_a_sel = 1'b1;
        d.alu_b_sel = 2'b11;
      end
      OPC_JALR: begin
        d.rd_en     = 1'b1;
        d.branch_op = 3'b010;
        d.alu_a_sel = 1'b1;
        d.alu_b_sel = 2'b11;
      end
      OPC_BRANCH: begin
        d.ext_op    = 3'b011;
        d.branch_op = {1'b1, f3[2], f3[0]};
        d.alu_ctrl  = (f3[2] & f3[1]) ? 4'b1010 : 4'b0010;
        d.alu_b_sel = 2'b01;
        bad         = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD: begin
        d.rd_en  = 1'b1;
        d.rd_mem = 1'b1;
        bad      = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        d.ext_op = 3'b010;
        d.wr_mem = 1'b1;
        bad      = (f3 > 3'b010);
      end
      OPC_OPIMM: begin
        d.rd_en    = 1'b1;
        d.alu_ctrl = {(f3 == 3'b101) & f7[5], f3};
      end
      OPC_OP: begin
        d.rd_en     = 1'b1;
        d.alu_b_sel = 2'b01;
        if (ENABLE_M && f7 == 7'b0000001) begin
          d.mul_en   = 1'b1;
          d.alu_ctrl = 4'b0000;
        end else begin
          d.alu_ctrl = {f7[5], f3};
          if (f7 == 7'b0100000)
            bad = (f3 != 3'b000) && (f3 != 3'b101);
          else
            bad = (f7 != 7'b0000000);
        end
      end
      OPC_SYSTEM: begin
        if (ENABLE_CSR) begin
          d.rd_en    = 1'b1;
          d.csr_en   = (f3 != 3'b000);
          d.sys_trap = (f3 == 3'b000);
        end else begin
          bad = 1'b1;
        end
      end
      default: bad = 1'b1;
    endcase
    // Illegal entries still flow to EXU, but with every side effect suppressed.
    if (bad) begin
      d.rd_mem    = 1'b0;
      d.wr_mem    = 1'b0;
      d.rd_en     = 1'b0;
      d.mul_en    = 1'b0;
      d.csr_en    = 1'b0;
      d.sys_trap  = 1'b0;
      d.branch_op = 3'b000;
    end
    d.illegal = bad;
    return d;
  endfunction

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  entry_t          dec;
  entry_t          head;
  logic            ready;
  logic            valid;
  logic            push;
  logic            pop;

  always_comb begin
    dec = decode(bus.in_inst, bus.in_pc);
  end

  assign ready = (count < FULL);
  assign valid = (count != '0);
  assign push  = bus.in_valid & ready & ~bus.flush;
  assign pop   = valid & bus.out_ready & ~bus.flush;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      // Storage is left stale; only the bookkeeping is cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.in_ready           = ready;
  assign bus.out_valid          = valid;
  assign bus.out_pc             = head.pc;
  assign bus.out_inst           = head.inst;
  assign bus.out_extOP          = head.ext_op;
  assign bus.out_readMemEnable  = head.rd_mem;
  assign bus.out_writeMemEnable = head.wr_mem;
  assign bus.out_rdEnable       = head.rd_en;
  assign bus.out_memOP          = head.mem_op;
  assign bus.out_branchOP       = head.branch_op;
  assign bus.out_ALUCtrl        = head.alu_ctrl;
  assign bus.out_ALUASel        = head.alu_a_sel;
  assign bus.out_ALUBSel        = head.alu_b_sel;
  assign bus.out_mulEn          = head.mul_en;
  assign bus.out_csrEn          = head.csr_en;
  assign bus.out_sysTrap        = head.sys_trap;
  assign bus.out_illegal        = head.illegal;

endmodule
